// File: rtl/decode_skid_if.sv
// decode_skid_if: handshake and payload bundle between the decoder, the
// decode skid buffer and rename.
//   Decoder side : i_valid, o_ready, i_pc, i_rs1, i_rs2, i_rd, i_immediate,
//                  i_ALUsrc, i_Branch, i_ALUOp, i_FUtype, i_Memread,
//                  i_Memwrite, i_Regwrite
//   Rename side  : o_valid, i_ready, o_pc, o_rs1, o_rs2, o_rd, o_immediate,
//                  o_ALUsrc, o_Branch, o_ALUOp, o_FUtype, o_Memread,
//                  o_Memwrite, o_Regwrite, o_count
// Modports: slave  = the skid buffer (consumes i_*, produces o_*)
//           master = the environment around it (decoder + rename)
interface decode_skid_if #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 32
) ();
  logic              i_valid;
  logic              o_ready;
  logic [PC_W-1:0]   i_pc;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [4:0]        i_rd;
  logic [DATA_W-1:0] i_immediate;
  logic              i_ALUsrc;
  logic              i_Branch;
  logic [1:0]        i_ALUOp;
  logic [1:0]        i_FUtype;
  logic              i_Memread;
  logic              i_Memwrite;
  logic              i_Regwrite;

  logic              o_valid;
  logic              i_ready;
  logic [PC_W-1:0]   o_pc;
  logic [4:0]        o_rs1;
  logic [4:0]        o_rs2;
  logic [4:0]        o_rd;
  logic [DATA_W-1:0] o_immediate;
  logic              o_ALUsrc;
  logic              o_Branch;
  logic [1:0]        o_ALUOp;
  logic [1:0]        o_FUtype;
  logic              o_Memread;
  logic              o_Memwrite;
  logic              o_Regwrite;
  logic [1:0]        o_count;

  modport slave (
    input  i_valid, i_pc, i_rs1, i_rs2, i_rd, i_immediate, i_ALUsrc, i_Branch,
           i_ALUOp, i_FUtype, i_Memread, i_Memwrite, i_Regwrite, i_ready,
    output o_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_immediate, o_ALUsrc,
           o_Branch, o_ALUOp, o_FUtype, o_Memread, o_Memwrite, o_Regwrite,
           o_count
  );

  modport master (
    output i_valid, i_pc, i_rs1, i_rs2, i_rd, i_immediate, i_ALUsrc, i_Branch,
           i_ALUOp, i_FUtype, i_Memread, i_Memwrite, i_Regwrite, i_ready,
    input  o_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_immediate, o_ALUsrc,
           o_Branch, o_ALUOp, o_FUtype, o_Memread, o_Memwrite, o_Regwrite,
           o_count
  );
endinterface

// File: rtl/decode_skid_buffer.sv
// decode_skid_buffer: two-entry, full-throughput skid buffer between the
// decoder and rename. Every output is decoded from flops, so o_ready has no
// combinational path from i_ready / i_valid.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   bus      - decode_skid_if.slave: decoder valid/ready + payload in,
//              rename valid/ready + payload out, o_count occupancy
//   i_flush  - synchronous pipeline flush, highest priority
//              (present only when DECODE_SKID_FLUSH_EN is defined)
// Optional feature macro: DECODE_SKID_FLUSH_EN
module decode_skid_buffer #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef DECODE_SKID_FLUSH_EN
  input  logic                 i_flush,
`endif
  decode_skid_if.slave         bus
);

  // pc + rs1/rs2/rd + immediate + 9 control bits
  localparam int PAY_W = PC_W + 15 + DATA_W + 9;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic [PAY_W-1:0] pay_in;
  logic             in_fire;
  logic             out_fire;
  logic             flush;

  assign pay_in = {bus.i_pc, bus.i_rs1, bus.i_rs2, bus.i_rd, bus.i_immediate,
                   bus.i_ALUsrc, bus.i_Branch, bus.i_ALUOp, bus.i_FUtype,
                   bus.i_Memread, bus.i_Memwrite, bus.i_Regwrite};

`ifdef DECODE_SKID_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  assign bus.o_valid = (state_q != EMPTY);
  assign bus.o_ready = (state_q != FULL);
  assign bus.o_count = (state_q == FULL) ? 2'd2 :
                       (state_q == BUSY) ? 2'd1 : 2'd0;

  assign in_fire  = bus.i_valid & bus.o_ready;
  assign out_fire = bus.o_valid & bus.i_ready;

  assign {bus.o_pc, bus.o_rs1, bus.o_rs2, bus.o_rd, bus.o_immediate,
          bus.o_ALUsrc, bus.o_Branch, bus.o_ALUOp, bus.o_FUtype,
          bus.o_Memread, bus.o_Memwrite, bus.o_Regwrite} = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload is left as is; it is don't-care once the entries are invalid.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = pay_in;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = pay_in;
          end else if (in_fire) begin
            skid_d  = pay_in;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // o_ready is low here, so no input can arrive alongside the dequeue.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_decode_skid_buffer.sv
module tb_decode_skid_buffer;
  localparam int PC_W   = 9;
  localparam int DATA_W = 32;
  localparam int PW     = PC_W + 15 + DATA_W + 9;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [PW-1:0] pay_drv;
  logic [PW-1:0] pay_obs;
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] q[$];   // reference model: FIFO contents, head at index 0

  always #5 clk = ~clk;

  decode_skid_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  decode_skid_buffer #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef DECODE_SKID_FLUSH_EN
    .i_flush(flush),
`endif
    .bus(bus)
  );

  assign {bus.i_pc, bus.i_rs1, bus.i_rs2, bus.i_rd, bus.i_immediate,
          bus.i_ALUsrc, bus.i_Branch, bus.i_ALUOp, bus.i_FUtype,
          bus.i_Memread, bus.i_Memwrite, bus.i_Regwrite} = pay_drv;
  assign pay_obs = {bus.o_pc, bus.o_rs1, bus.o_rs2, bus.o_rd, bus.o_immediate,
                    bus.o_ALUsrc, bus.o_Branch, bus.o_ALUOp, bus.o_FUtype,
                    bus.o_Memread, bus.o_Memwrite, bus.o_Regwrite};

  function automatic logic [PW-1:0] mk(input logic [PC_W-1:0] pc,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
      input logic [DATA_W-1:0] imm, input logic alusrc, input logic br,
      input logic [1:0] aluop, input logic [1:0] fu, input logic mr,
      input logic mw, input logic rw);
    return {pc, rs1, rs2, rd, imm, alusrc, br, aluop, fu, mr, mw, rw};
  endfunction

  // ADD, ADDI, LW, SW, BEQ, LUI, AUIPC, JAL, JALR at pc = 4*k
  function automatic logic [PW-1:0] instr(input int k);
    logic [PC_W-1:0] pc;
    pc = PC_W'(4 * k);
    case (k)
      0: return mk(pc, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
      1: return mk(pc, 5'd1, 5'd0, 5'd4, 32'd5,          1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      2: return mk(pc, 5'd7, 5'd0, 5'd6, 32'd8,          1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1);
      3: return mk(pc, 5'd7, 5'd5, 5'd0, 32'd12,         1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0);
      4: return mk(pc, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8,  1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
      5: return mk(pc, 5'd0, 5'd0, 5'd8, 32'h1234_5000,  1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
      6: return mk(pc, 5'd0, 5'd0, 5'd9, 32'h0000_1000,  1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
      7: return mk(pc, 5'd0, 5'd0, 5'd1, 32'd16,         1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
      default: return mk(pc, 5'd1, 5'd0, 5'd0, 32'd0,    1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    endcase
  endfunction

  function automatic logic [PW-1:0] rnd_pay();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("o_valid", 128'(bus.o_valid), 128'(q.size() != 0));
    check("o_ready", 128'(bus.o_ready), 128'(q.size() < 2));
    check("o_count", 128'(bus.o_count), 128'(q.size()));
    if (q.size() != 0) check("head_payload", 128'(pay_obs), 128'(q[0]));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at
  // the next falling edge.
  task automatic cycle(input logic v, input logic r, input logic [PW-1:0] p, input logic f);
    logic in_f, out_f;
    bus.i_valid = v;
    bus.i_ready = r;
    pay_drv     = p;
    flush       = f;
    in_f  = v && (q.size() < 2);
    out_f = r && (q.size() > 0);
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(p);
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [PW-1:0] cur;
    logic          cur_v;
    rst = 1'b1;
    flush = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    pay_drv = instr(0);

    // Reset held three cycles with i_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_o_valid", 128'(bus.o_valid), 128'(0));
      check("rst_o_ready", 128'(bus.o_ready), 128'(1));
      check("rst_o_count", 128'(bus.o_count), 128'(0));
      check("rst_o_pc",    128'(bus.o_pc),    128'(0));
    end
    rst = 1'b0;

    // Streaming nine instructions
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, 1'b1, instr(k), 1'b0);
      check("stream_pc", 128'(bus.o_pc), 128'(4 * k));
      if (k == 2) begin
        check("lw_rs1",   128'(bus.o_rs1),       128'(7));
        check("lw_rd",    128'(bus.o_rd),        128'(6));
        check("lw_imm",   128'(bus.o_immediate), 128'(8));
        check("lw_fu",    128'(bus.o_FUtype),    128'(2));
        check("lw_mread", 128'(bus.o_Memread),   128'(1));
      end
    end
    cycle(1'b0, 1'b1, instr(0), 1'b0);

    // Skid capture with i_ready low for three cycles
    cycle(1'b1, 1'b1, instr(0), 1'b0);
    cycle(1'b1, 1'b1, instr(1), 1'b0);
    cycle(1'b1, 1'b0, instr(2), 1'b0);
    check("skid_count", 128'(bus.o_count), 128'(2));
    check("skid_head",  128'(bus.o_pc),    128'(9'h04));
    cycle(1'b1, 1'b0, instr(3), 1'b0);
    check("skid_hold",  128'(bus.o_pc),    128'(9'h04));
    cycle(1'b1, 1'b0, instr(3), 1'b0);
    check("skid_ready", 128'(bus.o_ready), 128'(0));
    cycle(1'b1, 1'b1, instr(3), 1'b0);
    check("resume_08",  128'(bus.o_pc),    128'(9'h08));
    cycle(1'b1, 1'b1, instr(3), 1'b0);
    check("resume_0c",  128'(bus.o_pc),    128'(9'h0C));
    cycle(1'b0, 1'b1, instr(0), 1'b0);

    // Drain from FULL
    cycle(1'b1, 1'b0, instr(4), 1'b0);
    cycle(1'b1, 1'b0, instr(5), 1'b0);
    check("drain_full", 128'(bus.o_count), 128'(2));
    cycle(1'b0, 1'b1, instr(0), 1'b0);
    check("drain_14",   128'(bus.o_pc),    128'(9'h14));
    cycle(1'b0, 1'b1, instr(0), 1'b0);
    check("drain_empty", 128'(bus.o_valid), 128'(0));

    // Asynchronous reset while FULL
    cycle(1'b1, 1'b0, instr(4), 1'b0);
    cycle(1'b1, 1'b0, instr(5), 1'b0);
    bus.i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_o_valid", 128'(bus.o_valid), 128'(0));
    check("arst_o_count", 128'(bus.o_count), 128'(0));
    check("arst_o_pc",    128'(bus.o_pc),    128'(0));
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b1, instr(6), 1'b0);
    check("post_rst_18", 128'(bus.o_pc), 128'(9'h18));
    cycle(1'b0, 1'b1, instr(0), 1'b0);

`ifdef DECODE_SKID_FLUSH_EN
    // Flush while FULL with a competing input
    cycle(1'b1, 1'b0, instr(7), 1'b0);
    cycle(1'b1, 1'b0, instr(8), 1'b0);
    check("fl_full", 128'(bus.o_count), 128'(2));
    cycle(1'b1, 1'b0, instr(9), 1'b1);
    check("fl_valid", 128'(bus.o_valid), 128'(0));
    check("fl_count", 128'(bus.o_count), 128'(0));
    repeat (3) begin
      cycle(1'b0, 1'b1, instr(0), 1'b0);
      check("fl_no24", 128'(bus.o_valid), 128'(0));
    end
`endif

    // Randomized traffic; the decoder holds its payload while stalled
    cur = rnd_pay();
    cur_v = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic v, r, f, acc;
      if (!(cur_v && q.size() == 2)) begin
        v = ($urandom_range(0, 3) != 0);
        cur = rnd_pay();
      end else v = 1'b1;
      r = ($urandom_range(0, 2) != 0);
`ifdef DECODE_SKID_FLUSH_EN
      f = ($urandom_range(0, 40) == 0);
`else
      f = 1'b0;
`endif
      acc = v && (q.size() < 2);
      cycle(v, r, cur, f);
      cur_v = v && !acc && !f;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
